// File: rtl/input_port_irq_pkg.sv
// Shared definitions for the key/switch input port: ctrl and status bit
// positions plus the interrupt FSM encoding.
package input_port_irq_pkg;

  // ctrl (CPU output port) bit positions
  localparam int CTRL_ACK     = 0;
  localparam int CTRL_INT_EN  = 1;
  localparam int CTRL_CLR_OVR = 2;

  // status (CPU input port) bit positions
  localparam int STAT_PEND    = 0;
  localparam int STAT_OVR     = 1;

  // Interrupt FSM: pending is simply "in ST_PEND"
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } irq_state_t;

endpackage

// File: rtl/input_port_irq_port_debounce.sv
// Whole-word synchroniser and debouncer for the raw key bus. A new word is
// accepted once it has been seen unchanged at the synchroniser output for
// DEBOUNCE_CYCLES consecutive samples. accept is a one-cycle combinational
// strobe valid on the edge where stable takes the candidate value.
module port_debounce
  import input_port_irq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] cand,
  output logic             accept
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, stable_q;
  logic [CNT_W-1:0] cnt_q;

  logic same, settled;

  assign same    = (sync2_q == cand_q);
  assign settled = (cnt_q == CNT_MAX);
  assign accept  = same && settled && (cand_q != stable_q);
  assign stable  = stable_q;
  assign cand    = cand_q;

  // Two-flop synchroniser for the asynchronous key levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Any change restarts the count; counter saturates, never wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else if (!same) begin
      cand_q <= sync2_q;
      cnt_q  <= '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (cand_q != stable_q) begin
      stable_q <= cand_q;
    end
  end

endmodule

// File: rtl/input_port_irq.sv
// CPU input port for the debounced key bus. Latches each accepted key word,
// raises a level interrupt on every acceptance, and flags overrun when a new
// word arrives before the previous one was acknowledged.
module input_port_irq
  import input_port_irq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_in,
  input  logic [7:0]       ctrl,
  output logic [WIDTH-1:0] data_out,
  output logic [7:0]       status,
  output logic             pint
);

  logic [WIDTH-1:0] db_stable, db_cand;
  logic             db_accept;

  logic [WIDTH-1:0] data_q;
  logic             ack_prev_q;
  logic             ovr_q;
  irq_state_t       state_q;

  logic ack_rise, pending;
  logic ctrl_unused;

  port_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw    (keys_in),
    .stable (db_stable),
    .cand   (db_cand),
    .accept (db_accept)
  );

  // Ack is edge-triggered so a held ack bit clears only one event
  assign ack_rise    = ctrl[CTRL_ACK] & ~ack_prev_q;
  assign pending     = (state_q == ST_PEND);
  assign ctrl_unused = ^{ctrl[7:3], db_stable};

  // Data register loads the candidate on the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          data_q <= '0;
    else if (db_accept) data_q <= db_cand;
  end

  // Previous ack level for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack_prev_q <= 1'b0;
    else       ack_prev_q <= ctrl[CTRL_ACK];
  end

  // Interrupt FSM with sticky overrun; a new overrun beats clr_ovr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ovr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (db_accept) state_q <= ST_PEND;
        ST_PEND: if (ack_rise && !db_accept) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (pending && db_accept && !ack_rise) ovr_q <= 1'b1;
      else if (ctrl[CTRL_CLR_OVR])           ovr_q <= 1'b0;
    end
  end

  assign data_out = data_q;
  assign status   = {6'b0, ovr_q, pending};
  assign pint     = pending & ctrl[CTRL_INT_EN];

endmodule
